pic_display_ctrl: RTL

- Parametrised picture-overlay engine for the VGA pipeline.
- Maps the scan position (h_addr, v_addr) onto a movable IMG_W x IMG_H window.
- Fetches pixels from an external synchronous image ROM with configurable latency.
- Expands packed PIX_W-bit RGB to 24-bit vga_data; pixels outside the window get BG_COLOR.
- Window position is static, horizontally scrolling, bouncing or frozen, updated once per frame.

---
 rtl/pic_display_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pic_display_ctrl.sv
// pic_display_ctrl
//   Picture-overlay engine for the VGA pipeline. The current scan position is
//   mapped onto a movable IMG_W x IMG_H window. Scan points inside the window
//   fetch a packed RGB pixel from an external synchronous image ROM. That pixel
//   is expanded to 24-bit colour. Points outside the window get BG_COLOR. The
//   window origin is updated once per frame. It can be static, scroll
//   horizontally, bounce, or be frozen.
//
// Ports
//   clk       pixel clock (only clock)
//   rst       synchronous active-high reset
//   en        display enable; 0 blanks vga_data while the pipeline keeps running
//   mode      00 STATIC, 01 HSCROLL, 10 BOUNCE, 11 FREEZE (sampled on frame tick)
//   h_addr    current scan column
//   v_addr    current scan row
//   rom_addr  registered image ROM address (row-major inside the window)
//   rom_data  image ROM read data, valid ROM_LAT cycles after rom_addr
//   vga_data  registered {R,G,B} output, ROM_LAT+2 cycles after h_addr/v_addr
//   pos_x     current window X origin
//   pos_y     current window Y origin
module pic_display_ctrl #(
  parameter int          PIX_W    = 12,
  parameter int          IMG_W    = 256,
  parameter int          IMG_H    = 192,
  parameter int          ADDR_W   = 16,
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          ROM_LAT  = 1,
  parameter int          STEP     = 2,
  parameter int          X_INIT   = 0,
  parameter int          Y_INIT   = 0,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [9:0]        h_addr,
  input  logic [9:0]        v_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [23:0]       vga_data,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y
);

  localparam int          C      = PIX_W / 3;
  localparam logic [10:0] XL     = 11'(H_ACTIVE - IMG_W);
  localparam logic [10:0] YL     = 11'(V_ACTIVE - IMG_H);
  localparam logic [10:0] IW11   = 11'(IMG_W);
  localparam logic [10:0] IH11   = 11'(IMG_H);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [9:0]  STEP10 = 10'(STEP);

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'b00,
    MODE_HSCROLL = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_FREEZE  = 2'b11
  } mode_t;

  mode_t               r_mode;
  logic [9:0]          r_pos_x, r_pos_y;
  logic                r_dir_x, r_dir_y;     // 1 = moving positive
  logic                r_prev_zero;
  logic                r_in_s1, r_en_s1;
  logic [ROM_LAT-1:0]  r_in_dly, r_en_dly;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [23:0]         r_vga;

  logic                w_at_zero, w_tick, w_inside;
  mode_t               w_mode;
  logic [9:0]          w_dx, w_dy;
  logic [ADDR_W-1:0]   w_lin;
  logic [9:0]          w_pos_x_n, w_pos_y_n;
  logic                w_dir_x_n, w_dir_y_n;

  // Widen a C-bit channel to 8 bits by repeating it MSB-first.
  function automatic logic [7:0] expand(input logic [C-1:0] c);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) e[7-i] = c[C-1-(i%C)];
    return e;
  endfunction

  // One axis of the bounce motion: reflect at 0 and at lim.
  function automatic void bounce(input logic [9:0] p, input logic d,
                                 input logic [10:0] lim,
                                 output logic [9:0] p_n, output logic d_n);
    if (d) begin
      if (({1'b0, p} + STEP11) > lim) begin
        d_n = 1'b0;
        p_n = p - STEP10;
      end else begin
        d_n = 1'b1;
        p_n = p + STEP10;
      end
    end else begin
      if (p < STEP10) begin
        d_n = 1'b1;
        p_n = p + STEP10;
      end else begin
        d_n = 1'b0;
        p_n = p - STEP10;
      end
    end
  endfunction

  // A frame tick fires only on the first cycle at (0,0), so a scan source
  // that dwells on the origin still moves the window once per frame.
  assign w_at_zero = (h_addr == 10'd0) && (v_addr == 10'd0);
  assign w_tick    = w_at_zero && !r_prev_zero;
  assign w_mode    = w_tick ? mode_t'(mode) : r_mode;

  // Bounds are computed in 11 bits so x0+IMG_W cannot wrap.
  assign w_inside = (h_addr >= r_pos_x) && ({1'b0, h_addr} < ({1'b0, r_pos_x} + IW11)) &&
                    (v_addr >= r_pos_y) && ({1'b0, v_addr} < ({1'b0, r_pos_y} + IH11));
  assign w_dx  = h_addr - r_pos_x;
  assign w_dy  = v_addr - r_pos_y;
  assign w_lin = ADDR_W'(w_dy) * ADDR_W'(IMG_W) + ADDR_W'(w_dx);

  always_comb begin
    w_pos_x_n = r_pos_x;
    w_pos_y_n = r_pos_y;
    w_dir_x_n = r_dir_x;
    w_dir_y_n = r_dir_y;
    if (w_tick) begin
      case (w_mode)
        MODE_STATIC: begin
          w_pos_x_n = 10'(X_INIT);
          w_pos_y_n = 10'(Y_INIT);
        end
        MODE_HSCROLL: begin
          w_pos_x_n = (({1'b0, r_pos_x} + STEP11) > XL) ? 10'd0 : r_pos_x + STEP10;
        end
        MODE_BOUNCE: begin
          bounce(r_pos_x, r_dir_x, XL, w_pos_x_n, w_dir_x_n);
          bounce(r_pos_y, r_dir_y, YL, w_pos_y_n, w_dir_y_n);
        end
        default: begin
          // FREEZE: hold position and directions
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= MODE_STATIC;
      r_pos_x     <= 10'(X_INIT);
      r_pos_y     <= 10'(Y_INIT);
      r_dir_x     <= 1'b1;
      r_dir_y     <= 1'b1;
      r_prev_zero <= 1'b0;
      r_in_s1     <= 1'b0;
      r_en_s1     <= 1'b0;
      r_in_dly    <= '0;
      r_en_dly    <= '0;
      r_rom_addr  <= '0;
      r_vga       <= 24'h000000;
    end else begin
      r_prev_zero <= w_at_zero;
      r_mode      <= w_mode;
      r_pos_x     <= w_pos_x_n;
      r_pos_y     <= w_pos_y_n;
      r_dir_x     <= w_dir_x_n;
      r_dir_y     <= w_dir_y_n;

      // Stage 1: window test and address; address holds while outside.
      r_in_s1 <= w_inside;
      r_en_s1 <= en;
      if (w_inside) r_rom_addr <= w_lin;

      // Delay line aligning inside/en with rom_data.
      r_in_dly[0] <= r_in_s1;
      r_en_dly[0] <= r_en_s1;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_in_dly[i] <= r_in_dly[i-1];
        r_en_dly[i] <= r_en_dly[i-1];
      end

      // Output stage.
      if (!r_en_dly[ROM_LAT-1])
        r_vga <= 24'h000000;
      else if (!r_in_dly[ROM_LAT-1])
        r_vga <= BG_COLOR;
      else
        r_vga <= {expand(rom_data[PIX_W-1 -: C]),
                  expand(rom_data[2*C-1 -: C]),
                  expand(rom_data[C-1:0])};
    end
  end

  assign rom_addr = r_rom_addr;
  assign vga_data = r_vga;
  assign pos_x    = r_pos_x;
  assign pos_y    = r_pos_y;

endmodule
